// File: rtl/timer_arbiter_pkg.sv
// rtl/timer_arbiter_pkg.sv - shared state encoding and rate-code constants for the timer arbiter
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] RATE_1HZ  = 2'd0;
    localparam logic [1:0] RATE_4HZ  = 2'd1;
    localparam logic [1:0] RATE_60HZ = 2'd2;
    localparam logic [1:0] RATE_MIN  = 2'd3;

    localparam int unsigned CLK_HZ = 50_000_000;

endpackage

// File: rtl/timer_arbiter_if.sv
// rtl/timer_arbiter_if.sv - requester-facing signal bundle of the shared delay timer
interface timer_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 28
);
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] rate_sel;
    logic                 pause;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic                 tick;
    logic [CNT_W-1:0]     count;

    modport master (
        output req, rate_sel, pause,
        input  grant, done, busy, tick, count
    );

    modport slave (
        input  req, rate_sel, pause,
        output grant, done, busy, tick, count
    );
endinterface

// File: rtl/timer_arbiter_rr_pick.sv
// rtl/timer_arbiter_rr_pick.sv - combinational round-robin picker: first set req at or above ptr, wrapping
module timer_arbiter_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] id,
    output logic           valid
);
    localparam logic [IDW:0] NV = (IDW+1)'(N);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit is then the winner.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        valid = 1'b0;
        off   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                valid = 1'b1;
                off   = IDW'(j);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NV) begin
            sum = sum - NV;
        end
        id   = sum[IDW-1:0];
        pick = valid ? (N'(1) << id) : '0;
    end
endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin sharing of one down-counting delay timer among NUM_REQ requesters
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter int          CNT_W   = 28,
    parameter int unsigned RATE0   = 49_999_999,
    parameter int unsigned RATE1   = 12_499_999,
    parameter int unsigned RATE2   = 833_332,
    parameter int unsigned RATE3   = 0
) (
    input  logic            clock,
    input  logic            reset,
    timer_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NUM_REQ);

    state_t             state, state_next;
    logic [IDW-1:0]     id;
    logic [IDW-1:0]     rr_ptr;
    logic [1:0]         code;
    logic [NUM_REQ-1:0] grant;
    logic [CNT_W-1:0]   count;

    logic [NUM_REQ-1:0] pick;
    logic [IDW-1:0]     pick_id;
    logic               pick_valid;
    logic [1:0]         code_sel;

    logic take, load, dec, release_owner;

    timer_arbiter_rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .pick  (pick),
        .id    (pick_id),
        .valid (pick_valid)
    );

    assign code_sel = bus.rate_sel[{pick_id, 1'b0} +: 2];

    function automatic logic [CNT_W-1:0] rate_value(input logic [1:0] c);
        case (c)
            RATE_1HZ:  rate_value = CNT_W'(RATE0);
            RATE_4HZ:  rate_value = CNT_W'(RATE1);
            RATE_60HZ: rate_value = CNT_W'(RATE2);
            default:   rate_value = CNT_W'(RATE3);
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A dropped req of the owner cancels, and wins over expiry in the same cycle.
    always_comb begin
        state_next    = state;
        take          = 1'b0;
        load          = 1'b0;
        dec           = 1'b0;
        release_owner = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    take       = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!bus.req[id]) begin
                    release_owner = 1'b1;
                    state_next    = ST_IDLE;
                end else begin
                    load       = 1'b1;
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!bus.req[id]) begin
                    release_owner = 1'b1;
                    state_next    = ST_IDLE;
                end else if (count == '0) begin
                    state_next = ST_DONE;
                end else if (!bus.pause) begin
                    dec = 1'b1;
                end
            end
            ST_DONE: begin
                release_owner = 1'b1;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id     <= '0;
            rr_ptr <= '0;
            code   <= '0;
            grant  <= '0;
            count  <= '0;
        end else begin
            if (take) begin
                grant <= pick;
                id    <= pick_id;
                code  <= code_sel;
            end
            if (release_owner) begin
                grant  <= '0;
                rr_ptr <= (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
            end
            if (load) begin
                count <= rate_value(code);
            end else if (dec) begin
                count <= count - 1'b1;
            end
        end
    end

    assign bus.grant = grant;
    assign bus.done  = (state == ST_DONE) ? grant : '0;
    assign bus.tick  = (state == ST_DONE);
    assign bus.busy  = (state != ST_IDLE);
    assign bus.count = count;

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one down-counting delay timer among NUM_REQ requesters, e.g. game-object movers, flash/blink logic and the screen-refresh sequencer.
- Each requester raises req with a rate code. The arbiter grants round-robin, loads the timer from a per-code constant table, counts it down to zero, then pulses done to the winner.
- Sits between game-logic FSMs and the single timing resource, so the design needs only one wide counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 28, timer width
- RATE0, 49_999_999, load value for code 0 (1 Hz at 50 MHz)
- RATE1, 12_499_999, load value for code 1 (4 Hz)
- RATE2, 833_332, load value for code 2 (60 Hz)
- RATE3, 0, load value for code 3 (minimum delay)

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held until done, or dropped to cancel
- rate_sel  in  2*NUM_REQ  rate code per requester; bits [2i+1:2i] belong to requester i
- pause  in  1  freezes countdown while high
- grant  out  NUM_REQ  one-hot; requester currently owning the timer
- done  out  NUM_REQ  one-hot, one-cycle pulse on delay expiry
- busy  out  1  high in any state other than IDLE
- tick  out  1  OR of done
- count  out  CNT_W  current timer value, for debug/HEX display

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE, count=0, rr_ptr=0, grant=0, done=0, busy=0, tick=0.
- The FSM has four states: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If any req bit is high, select the first high bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the selected id as grant (one-hot) and latch its rate_sel code, then go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD: count <= RATE[latched code]; go to COUNT. rate_sel changes after the grant edge are ignored.
- COUNT:
  - If count==0, go to DONE.
  - Else if pause==0, count <= count-1.
  - Else hold count.
- DONE:
  - done[id]=1 and tick=1 for exactly this one cycle.
  - grant clears on the exit edge.
  - rr_ptr <= (id+1) mod NUM_REQ.
  - Go to IDLE.
- Latency:
  - req is sampled high in IDLE at edge E0 and the load value is L.
  - With no pause, done is high in the cycle after edge E0+L+2.
  - The arbiter is back in IDLE after edge E0+L+3, giving L+3 cycles per service.
  - Each paused cycle in COUNT adds one cycle.
- Cancel:
  - If req[id] is low while in LOAD or COUNT, go to IDLE on that edge.
  - No done pulse is generated; grant clears and rr_ptr advances as in DONE.
  - A cancel in the same cycle that count==0 takes priority: no done pulse.
- A requester's req is ignored in DONE. The next IDLE search starts after it, so other pending requesters win first (fairness).
- Arithmetic:
  - count is unsigned CNT_W.
  - RATE3=0 gives done 2 cycles after grant.
  - There is no wrap-around: decrement occurs only when count≠0.
- Pause in IDLE, LOAD or DONE has no effect.
- busy=1 in LOAD, COUNT and DONE.
- A reset asserted mid-count aborts immediately. No done pulse is produced, and the arbiter is back in IDLE with rr_ptr=0 after reset deasserts.

Decomposition:
- Shared include tick_defs.vh holds:
  - state encodings (IDLE=2'd0, LOAD=2'd1, COUNT=2'd2, DONE=2'd3)
  - rate-code constants RATE_1HZ, RATE_4HZ, RATE_60HZ and RATE_MIN
  - CLK_HZ=50_000_000
- Sub-module rr_pick (combinational round-robin priority picker: req, rr_ptr -> one-hot pick, valid) is natural and is reused by future arbiters.
- The timer counter stays inline.

Test Plan:
- Test parameter overrides: RATE0=3, RATE1=0, RATE2=5.
- Scenario 1: reset, req=4'b0001, rate_sel[1:0]=0 -> grant=0001 after 1 edge, count loads 3, done[0] high in cycle E0+5, busy low after E0+6.
- Scenario 2: req=4'b1111, all codes 1 -> grants 0001, 0010, 0100, 1000, 0001 in that order; each done is 2 cycles after its grant.
- Scenario 3: req=4'b0100, code 2; pause high for 4 cycles mid-COUNT -> done[2] delayed exactly 4 cycles (E0+11); count holds its value while paused.
- Scenario 4: req[3] granted with code 0, then req[3] dropped while count=2 -> no done pulse, grant=0 next cycle, rr_ptr=0 so a subsequent req=4'b1001 grants 0001.
- Scenario 5: change rate_sel for the granted requester during COUNT -> expiry still uses the latched code; assert reset at count=1 -> all outputs 0 on the same cycle (async), with no done pulse.
- Scenario 6: req[1] held continuously with req[2] asserted during req[1]'s DONE -> next grant is 0100, not 0010.
